uart_tx_ctl: RTL



---
 rtl/uart_tx_ctl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctl.sv
// UART transmitter: pops bytes from a show-ahead FIFO and sends start, 8 data bits LSB-first, optional parity, and 1 or 2 stop bits.
// Latency: a frame starts on the first baud_x16_en tick that sees a non-empty FIFO, and each bit lasts 16 ticks.
// Backpressure: the FIFO is popped only when the previous frame has finished, and back-to-back frames are sent with no idle gap.
module uart_tx_ctl #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_tx,
    input  logic       rst_clk_tx_n,
    input  logic       baud_x16_en,
    input  logic       char_fifo_empty,
    input  logic [7:0] char_fifo_dout,
    output logic       char_fifo_rd_en,
    output logic       txd_tx,
    output logic       tx_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // The stop phase is timed by its own 5-bit counter so that two stop bits (32 ticks) fit in it.
    localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);
    localparam logic       ODD_INV   = (PARITY_ODD != 0);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);

    state_t     state, state_nxt;
    logic [3:0] os_cnt, os_cnt_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [4:0] stop_cnt, stop_cnt_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic       par_bit, par_nxt;
    logic       txd_nxt, busy_nxt, rd_nxt;
    logic       take_char;

    // Next-state logic. Output values are derived from the next state so that the output flops stay aligned with the state.
    always_comb begin
        state_nxt    = state;
        os_cnt_nxt   = os_cnt;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        shift_nxt    = shift_reg;
        par_nxt      = par_bit;
        rd_nxt       = 1'b0;
        take_char    = 1'b0;
        txd_nxt      = 1'b1;
        busy_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (baud_x16_en && !char_fifo_empty) begin
                    take_char = 1'b1;
                end
            end
            START: begin
                if (baud_x16_en) begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (baud_x16_en) begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        shift_nxt   = {1'b0, shift_reg[7:1]};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = HAS_PAR ? PARITY : STOP;
                        end
                    end
                end
            end
            PARITY: begin
                if (baud_x16_en) begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_x16_en) begin
                    stop_cnt_nxt = stop_cnt + 5'd1;
                    if (stop_cnt == STOP_LAST) begin
                        stop_cnt_nxt = 5'd0;
                        // Chain straight into the next frame when another byte is waiting.
                        if (!char_fifo_empty) begin
                            take_char = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Latch the head byte and its parity together, so that later changes on the FIFO bus cannot affect this frame.
        if (take_char) begin
            state_nxt   = START;
            os_cnt_nxt  = 4'd0;
            bit_cnt_nxt = 3'd0;
            shift_nxt   = char_fifo_dout;
            par_nxt     = (^char_fifo_dout) ^ ODD_INV;
            rd_nxt      = 1'b1;
        end

        case (state_nxt)
            START: begin
                txd_nxt  = 1'b0;
                busy_nxt = 1'b1;
            end
            DATA: begin
                txd_nxt  = shift_nxt[0];
                busy_nxt = 1'b1;
            end
            PARITY: begin
                txd_nxt  = par_nxt;
                busy_nxt = 1'b1;
            end
            STOP: begin
                txd_nxt  = 1'b1;
                busy_nxt = 1'b1;
            end
            default: begin
                txd_nxt  = 1'b1;
                busy_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and the registered outputs. Reset forces the line high immediately and drops any frame in progress.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state           <= IDLE;
            os_cnt          <= 4'd0;
            bit_cnt         <= 3'd0;
            stop_cnt        <= 5'd0;
            shift_reg       <= 8'd0;
            par_bit         <= 1'b0;
            txd_tx          <= 1'b1;
            tx_busy         <= 1'b0;
            char_fifo_rd_en <= 1'b0;
        end else begin
            state           <= state_nxt;
            os_cnt          <= os_cnt_nxt;
            bit_cnt         <= bit_cnt_nxt;
            stop_cnt        <= stop_cnt_nxt;
            shift_reg       <= shift_nxt;
            par_bit         <= par_nxt;
            txd_tx          <= txd_nxt;
            tx_busy         <= busy_nxt;
            char_fifo_rd_en <= rd_nxt;
        end
    end

endmodule
